// File: rtl/mux_8_1_rr_scheduler.sv
// ============================================================================
// Module   : mux_8_1_rr_scheduler
// Brief    : Round-robin arbiter driving the select of a shared 8:1 mux, with a
//            bounded grant length and a gated copy of the selected data bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_8_1_rr_scheduler #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] REQ,
  input  logic       DONE,
  input  logic [7:0] D,
  output logic [2:0] SEL,
  output logic [7:0] GNT,
  output logic       VALID,
  output logic       Z
);

  localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_pri;
  logic [3:0] r_cnt;

  logic [3:0] w_pick_idle;
  logic [3:0] w_pick_rel;
  logic       w_release;

  // Result bit 3 flags a winner; bits 2:0 hold its index. Scanning from
  // the top down lets the lowest rotated position (closest to base) win.
  function automatic logic [3:0] pick(input logic [2:0] base,
                                      input logic [7:0] req);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [3:0]  res;
    dbl = {req, req} >> base;
    rot = dbl[7:0];
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        res = {1'b1, base + 3'(i)};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_pick_idle = pick(r_pri, REQ);
    w_pick_rel  = pick(SEL + 3'd1, REQ);
    w_release   = !REQ[SEL] || DONE || (r_cnt == c_max_hold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pri   <= 3'd0;
      r_cnt   <= 4'd0;
      SEL     <= 3'd0;
      GNT     <= 8'd0;
      VALID   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_idle[3]) begin
            r_state <= ST_GRANT;
            SEL     <= w_pick_idle[2:0];
            GNT     <= 8'd1 << w_pick_idle[2:0];
            VALID   <= 1'b1;
            r_cnt   <= 4'd1;
          end else begin
            GNT     <= 8'd0;
            VALID   <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            // Outgoing owner drops to lowest priority; handover is bubble-free.
            r_pri <= SEL + 3'd1;
            if (w_pick_rel[3]) begin
              SEL   <= w_pick_rel[2:0];
              GNT   <= 8'd1 << w_pick_rel[2:0];
              VALID <= 1'b1;
              r_cnt <= 4'd1;
            end else begin
              r_state <= ST_IDLE;
              GNT     <= 8'd0;
              VALID   <= 1'b0;
              r_cnt   <= 4'd0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          GNT     <= 8'd0;
          VALID   <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign Z = VALID & D[SEL];

endmodule

`default_nettype wire
